// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with any depth, occupancy and threshold flags.
// Read mode is standard or FWFT; SYNC_FIFO_ERR_FLAGS_EN adds sticky error flags.
module sync_fifo_flags #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = 2,
    parameter int FWFT       = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  logic [DATA_WIDTH-1:0]        wr_data,
    input  logic                         rd_en,
    output logic [DATA_WIDTH-1:0]        rd_data,
    output logic                         rd_valid,
    output logic                         full,
    output logic                         empty,
    output logic                         almost_full,
    output logic                         almost_empty,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow,
    output logic                         underflow,
    input  logic                         err_clr
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEPTH);
    localparam logic [CW-1:0] AF_L     = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_L     = CW'(AE_LEVEL);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  wr_acc, rd_acc;

    assign full         = (count_q == CNT_MAX);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AF_L);
    assign almost_empty = (count_q <= AE_L);
    assign count        = count_q;

    // Acceptance, pointer wrap by compare, and occupancy next-state
    always_comb begin
        wr_acc   = wr_en & ~full;
        rd_acc   = rd_en & ~empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_acc) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1);
        end
        if (rd_acc) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PW'(1);
        end
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents survive reset, writes in the reset cycle are dropped
    always_ff @(posedge clk) begin
        if (wr_acc && !rst) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    if (FWFT != 0) begin : g_fwft
        // Head word shown directly; forced to zero while nothing is stored
        assign rd_data  = empty ? '0 : mem_q[rd_ptr_q];
        assign rd_valid = ~empty;
    end else begin : g_std
        logic [DATA_WIDTH-1:0] rd_data_q;
        logic                  rd_valid_q;

        // Registered read: data and one-cycle valid pulse per accepted read
        always_ff @(posedge clk) begin
            if (rst) begin
                rd_data_q  <= '0;
                rd_valid_q <= 1'b0;
            end else begin
                rd_valid_q <= rd_acc;
                if (rd_acc) begin
                    rd_data_q <= mem_q[rd_ptr_q];
                end
            end
        end

        assign rd_data  = rd_data_q;
        assign rd_valid = rd_valid_q;
    end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic overflow_q, underflow_q;

    // Sticky error flags; a new error in the clear cycle keeps the flag set
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= (wr_en & full) | (overflow_q & ~err_clr);
            underflow_q <= (rd_en & empty) | (underflow_q & ~err_clr);
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign overflow       = 1'b0;
    assign underflow      = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Bench for sync_fifo_flags: four instances cover depth 4, depth 5,
// threshold settings and FWFT mode, checked against a queue model.
module tb_sync_fifo_flags;

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    localparam bit ERR = 1'b1;
`else
    localparam bit ERR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // A: DEPTH=4 standard
    logic a_wr = 0, a_rd = 0, a_clr = 0;
    logic [7:0] a_wd = 0, a_rdata;
    logic a_rv, a_full, a_empty, a_af, a_ae, a_ovf, a_unf;
    logic [2:0] a_cnt;
    // B: DEPTH=5 standard
    logic b_wr = 0, b_rd = 0, b_clr = 0;
    logic [7:0] b_wd = 0, b_rdata;
    logic b_rv, b_full, b_empty, b_af, b_ae, b_ovf, b_unf;
    logic [2:0] b_cnt;
    // C: DEPTH=8, AF=6, AE=1
    logic c_wr = 0, c_rd = 0, c_clr = 0;
    logic [7:0] c_wd = 0, c_rdata;
    logic c_rv, c_full, c_empty, c_af, c_ae, c_ovf, c_unf;
    logic [3:0] c_cnt;
    // D: DEPTH=4 FWFT
    logic d_wr = 0, d_rd = 0, d_clr = 0;
    logic [7:0] d_wd = 0, d_rdata;
    logic d_rv, d_full, d_empty, d_af, d_ae, d_ovf, d_unf;
    logic [2:0] d_cnt;

    logic [7:0] q_a[$];
    logic [7:0] q_b[$];

    sync_fifo_flags #(.DATA_WIDTH(8), .DEPTH(4), .FWFT(0)) u_a (
        .clk(clk), .rst(rst), .wr_en(a_wr), .wr_data(a_wd), .rd_en(a_rd),
        .rd_data(a_rdata), .rd_valid(a_rv), .full(a_full), .empty(a_empty),
        .almost_full(a_af), .almost_empty(a_ae), .count(a_cnt),
        .overflow(a_ovf), .underflow(a_unf), .err_clr(a_clr));

    sync_fifo_flags #(.DATA_WIDTH(8), .DEPTH(5), .FWFT(0)) u_b (
        .clk(clk), .rst(rst), .wr_en(b_wr), .wr_data(b_wd), .rd_en(b_rd),
        .rd_data(b_rdata), .rd_valid(b_rv), .full(b_full), .empty(b_empty),
        .almost_full(b_af), .almost_empty(b_ae), .count(b_cnt),
        .overflow(b_ovf), .underflow(b_unf), .err_clr(b_clr));

    sync_fifo_flags #(.DATA_WIDTH(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(1),
                      .FWFT(0)) u_c (
        .clk(clk), .rst(rst), .wr_en(c_wr), .wr_data(c_wd), .rd_en(c_rd),
        .rd_data(c_rdata), .rd_valid(c_rv), .full(c_full), .empty(c_empty),
        .almost_full(c_af), .almost_empty(c_ae), .count(c_cnt),
        .overflow(c_ovf), .underflow(c_unf), .err_clr(c_clr));

    sync_fifo_flags #(.DATA_WIDTH(8), .DEPTH(4), .FWFT(1)) u_d (
        .clk(clk), .rst(rst), .wr_en(d_wr), .wr_data(d_wd), .rd_en(d_rd),
        .rd_data(d_rdata), .rd_valid(d_rv), .full(d_full), .empty(d_empty),
        .almost_full(d_af), .almost_empty(d_ae), .count(d_cnt),
        .overflow(d_ovf), .underflow(d_unf), .err_clr(d_clr));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        q_a.delete();
        q_b.delete();
        checks++; if ({a_cnt, a_empty, a_full, a_ae, a_af} !== {3'd0, 4'b1010}) begin failures++; $display("FAIL reset_a_flags got=%b want=%b", {a_cnt, a_empty, a_full, a_ae, a_af}, {3'd0, 4'b1010}); end
        checks++; if ({a_rv, a_rdata, a_ovf, a_unf} !== 11'd0) begin failures++; $display("FAIL reset_a_rd got=%h want=0", {a_rv, a_rdata, a_ovf, a_unf}); end
        checks++; if ({c_af, c_ae, c_empty} !== 3'b011) begin failures++; $display("FAIL reset_c_flags got=%b want=011", {c_af, c_ae, c_empty}); end
        checks++; if ({d_rv, d_rdata, d_empty} !== 10'b0_00000000_1) begin failures++; $display("FAIL reset_d got=%h want=1", {d_rv, d_rdata, d_empty}); end
        rst = 1'b0;
    endtask

    task automatic test_fill_drain();
        logic [7:0] exp;
        for (int i = 0; i < 4; i++) begin
            a_wr = 1'b1;
            a_wd = 8'hA1 + 8'(i);
            q_a.push_back(a_wd);
            tick();
        end
        a_wr = 1'b0;
        checks++; if ({a_full, a_cnt} !== {1'b1, 3'd4}) begin failures++; $display("FAIL fill_full got=%b/%0d want=1/4", a_full, a_cnt); end
        for (int i = 0; i < 5; i++) begin
            a_rd = 1'b1;
            tick();
            a_rd = 1'b0;
            if (q_a.size() > 0) begin
                exp = q_a.pop_front();
                checks++; if ({a_rv, a_rdata} !== {1'b1, exp}) begin failures++; $display("FAIL drain_data got=%b/%h want=1/%h", a_rv, a_rdata, exp); end
            end else begin
                checks++; if ({a_rv, a_empty} !== 2'b01) begin failures++; $display("FAIL drain_refused got rv=%b empty=%b want rv=0 empty=1", a_rv, a_empty); end
            end
            tick();
            checks++; if (a_rv !== 1'b0) begin failures++; $display("FAIL drain_pulse got=%b want=0", a_rv); end
        end
    endtask

    task automatic test_boundaries();
        logic [7:0] exp;
        for (int i = 0; i < 4; i++) begin
            a_wr = 1'b1;
            a_wd = 8'hB0 + 8'(i);
            q_a.push_back(a_wd);
            tick();
        end
        a_wd = 8'hEE;
        a_rd = 1'b1;
        tick();
        a_wr = 1'b0;
        a_rd = 1'b0;
        exp = q_a.pop_front();
        checks++; if (a_cnt !== 3'd3) begin failures++; $display("FAIL full_wr_rd_cnt got=%0d want=3", a_cnt); end
        checks++; if ({a_rv, a_rdata} !== {1'b1, exp}) begin failures++; $display("FAIL full_wr_rd_data got=%b/%h want=1/%h", a_rv, a_rdata, exp); end
        while (q_a.size() > 0) begin
            a_rd = 1'b1;
            tick();
            a_rd = 1'b0;
            exp = q_a.pop_front();
            checks++; if ({a_rv, a_rdata} !== {1'b1, exp}) begin failures++; $display("FAIL full_drop_readback got=%b/%h want=1/%h", a_rv, a_rdata, exp); end
            tick();
        end
        checks++; if ({a_empty, a_cnt} !== {1'b1, 3'd0}) begin failures++; $display("FAIL drop_empty got=%b/%0d want=1/0", a_empty, a_cnt); end
        a_wr = 1'b1;
        a_rd = 1'b1;
        a_wd = 8'h55;
        q_a.push_back(a_wd);
        tick();
        a_wr = 1'b0;
        a_rd = 1'b0;
        checks++; if ({a_cnt, a_rv} !== {3'd1, 1'b0}) begin failures++; $display("FAIL empty_wr_rd got=%0d/%b want=1/0", a_cnt, a_rv); end
        a_rd = 1'b1;
        tick();
        a_rd = 1'b0;
        exp = q_a.pop_front();
        checks++; if ({a_rv, a_rdata} !== {1'b1, exp}) begin failures++; $display("FAIL empty_wr_readback got=%b/%h want=1/%h", a_rv, a_rdata, exp); end
        tick();
    endtask

    task automatic test_wrap();
        int mcnt = 0;
        bit wacc, racc;
        logic [7:0] exp;
        for (int i = 0; i < 16; i++) begin
            b_wr = (i < 12);
            b_rd = (i >= 2);
            b_wd = 8'h10 + 8'(i);
            wacc = b_wr && (mcnt != 5);
            racc = b_rd && (mcnt != 0);
            exp = 8'h00;
            if (racc) exp = q_b.pop_front();
            if (wacc) q_b.push_back(b_wd);
            mcnt = mcnt + int'(wacc) - int'(racc);
            tick();
            checks++; if ({29'd0, b_cnt} !== mcnt) begin failures++; $display("FAIL wrap_cnt i=%0d got=%0d want=%0d", i, b_cnt, mcnt); end
            checks++; if (b_cnt > 3'd5) begin failures++; $display("FAIL wrap_cnt_max got=%0d want<=5", b_cnt); end
            checks++; if (b_rv !== racc) begin failures++; $display("FAIL wrap_valid i=%0d got=%b want=%b", i, b_rv, racc); end
            if (racc) begin
                checks++; if (b_rdata !== exp) begin failures++; $display("FAIL wrap_data i=%0d got=%h want=%h", i, b_rdata, exp); end
            end
        end
        b_wr = 1'b0;
        b_rd = 1'b0;
    endtask

    task automatic test_thresholds();
        for (int k = 1; k <= 16; k++) begin
            int n;
            n = (k <= 8) ? k : 16 - k;
            c_wr = (k <= 8);
            c_rd = (k > 8);
            c_wd = 8'(k);
            tick();
            checks++; if ({c_cnt, c_af, c_ae, c_full} !== {4'(n), n >= 6, n <= 1, n == 8}) begin failures++; $display("FAIL thresh n=%0d got cnt=%0d af=%b ae=%b full=%b", n, c_cnt, c_af, c_ae, c_full); end
        end
        c_wr = 1'b0;
        c_rd = 1'b0;
    endtask

    task automatic test_fwft();
        d_wr = 1'b1;
        d_wd = 8'h3C;
        tick();
        d_wr = 1'b0;
        checks++; if ({d_rv, d_rdata} !== {1'b1, 8'h3C}) begin failures++; $display("FAIL fwft_show got=%b/%h want=1/3c", d_rv, d_rdata); end
        d_rd = 1'b1;
        tick();
        d_rd = 1'b0;
        checks++; if ({d_empty, d_rv} !== 2'b10) begin failures++; $display("FAIL fwft_pop got empty=%b rv=%b want 1/0", d_empty, d_rv); end
        for (int i = 0; i < 2; i++) begin
            d_wr = 1'b1;
            d_wd = 8'h40 + 8'(i);
            tick();
        end
        d_wr = 1'b0;
        checks++; if (d_rdata !== 8'h40) begin failures++; $display("FAIL fwft_head0 got=%h want=40", d_rdata); end
        d_rd = 1'b1;
        tick();
        d_rd = 1'b0;
        checks++; if ({d_rv, d_rdata, d_cnt} !== {1'b1, 8'h41, 3'd1}) begin failures++; $display("FAIL fwft_head1 got=%b/%h/%0d want=1/41/1", d_rv, d_rdata, d_cnt); end
    endtask

    task automatic test_errors();
        for (int i = 0; i < 4; i++) begin
            a_wr = 1'b1;
            a_wd = 8'hC0 + 8'(i);
            tick();
        end
        checks++; if ({a_full, a_ovf} !== 2'b10) begin failures++; $display("FAIL err_prefull got=%b want=10", {a_full, a_ovf}); end
        tick();
        a_wr = 1'b0;
        checks++; if (a_ovf !== ERR) begin failures++; $display("FAIL err_ovf_set got=%b want=%b", a_ovf, ERR); end
        tick();
        tick();
        checks++; if (a_ovf !== ERR) begin failures++; $display("FAIL err_ovf_hold got=%b want=%b", a_ovf, ERR); end
        a_clr = 1'b1;
        tick();
        a_clr = 1'b0;
        checks++; if (a_ovf !== 1'b0) begin failures++; $display("FAIL err_ovf_clr got=%b want=0", a_ovf); end
        a_rd = 1'b1;
        repeat (4) tick();
        checks++; if ({a_empty, a_unf} !== 2'b10) begin failures++; $display("FAIL err_drained got=%b want=10", {a_empty, a_unf}); end
        a_clr = 1'b1;
        tick();
        a_rd = 1'b0;
        a_clr = 1'b0;
        checks++; if (a_unf !== ERR) begin failures++; $display("FAIL err_unf_setwins got=%b want=%b", a_unf, ERR); end
        a_wr = 1'b1;
        a_wd = 8'h77;
        a_rd = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        a_wr = 1'b0;
        checks++; if ({a_ovf, a_unf, a_cnt, a_empty, a_rv} !== {2'b00, 3'd0, 1'b1, 1'b0}) begin failures++; $display("FAIL err_rst got ovf=%b unf=%b cnt=%0d empty=%b rv=%b", a_ovf, a_unf, a_cnt, a_empty, a_rv); end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_boundaries();
        test_wrap();
        test_thresholds();
        test_fwft();
        test_errors();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
